// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//   Execute stage of the MIPS-style pipeline. It combines three functions:
//   ALU-control decode, the ALU with its zero flag, and the branch-target
//   adder. All results are registered at the EX/MEM boundary, and a stall
//   holds them.
//
//   Optional feature macro: ALU_OVERFLOW_DETECT_EN
//     defined   -> ovf reports signed overflow of ADD / SUB
//     undefined -> ovf is tied to 0 and no overflow logic is built
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-high; clears every output register
//     stall      in   1 = hold all output registers (has priority over loads)
//     in_valid   in   operands/controls valid this cycle
//     aluOp      in   2b main-control op: 00 add, 01 sub, 10 R-type, 11 ori
//     func       in   6b instruction[5:0]
//     shamt      in   5b instruction[10:6]
//     entr1      in   WIDTH operand A (rs)
//     entr2      in   WIDTH operand B (rt or immediate)
//     pc_plus4   in   WIDTH PC+4 of this instruction
//     imm_ext    in   WIDTH sign-extended immediate
//     alu_ctrl   out  4b registered decoded ALU opcode
//     alu_result out  WIDTH registered ALU result
//     zero       out  registered (alu_result == 0)
//     branch_pc  out  WIDTH registered pc_plus4 + (imm_ext << 2)
//     out_valid  out  registered in_valid
//     ovf        out  registered signed overflow
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       func,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] entr1,
    input  logic [WIDTH-1:0] entr2,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] imm_ext,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] branch_pc,
    output logic             out_valid,
    output logic             ovf
);

    // ALU opcodes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_INV  = 4'b1111;

    // ------------------------------------------------------------------
    // ALU-control decode
    // ------------------------------------------------------------------
    logic [3:0] ctrl_d;

    always_comb begin
        ctrl_d = OP_INV;
        unique case (aluOp)
            2'b00: ctrl_d = OP_ADD;
            2'b01: ctrl_d = OP_SUB;
            2'b11: ctrl_d = OP_OR;
            2'b10: begin
                case (func)
                    6'b100000: ctrl_d = OP_ADD;
                    6'b100010: ctrl_d = OP_SUB;
                    6'b100100: ctrl_d = OP_AND;
                    6'b100101: ctrl_d = OP_OR;
                    6'b100110: ctrl_d = OP_XOR;
                    6'b100111: ctrl_d = OP_NOR;
                    6'b101010: ctrl_d = OP_SLT;
                    6'b101011: ctrl_d = OP_SLTU;
                    6'b000000: ctrl_d = OP_SLL;
                    6'b000010: ctrl_d = OP_SRL;
                    6'b000011: ctrl_d = OP_SRA;
                    default:   ctrl_d = OP_INV;
                endcase
            end
            default: ctrl_d = OP_INV;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;

    assign sum  = entr1 + entr2;
    assign diff = entr1 - entr2;
    assign lt_s = $signed(entr1) < $signed(entr2);
    assign lt_u = entr1 < entr2;

    always_comb begin
        result_d = '0;
        case (ctrl_d)
            OP_ADD:  result_d = sum;
            OP_SUB:  result_d = diff;
            OP_AND:  result_d = entr1 & entr2;
            OP_OR:   result_d = entr1 | entr2;
            OP_XOR:  result_d = entr1 ^ entr2;
            OP_NOR:  result_d = ~(entr1 | entr2);
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_u};
            // Shifts operate on B (rt), amount from the instruction field
            OP_SLL:  result_d = entr2 << shamt;
            OP_SRL:  result_d = entr2 >> shamt;
            OP_SRA:  result_d = WIDTH'($signed(entr2) >>> shamt);
            default: result_d = '0;   // INVALID opcode yields 0 (and zero=1)
        endcase
    end

    assign zero_d = (result_d == '0);

    // ------------------------------------------------------------------
    // Overflow detect (optional)
    // ------------------------------------------------------------------
    logic ovf_d;

`ifdef ALU_OVERFLOW_DETECT_EN
    // ADD: operands share a sign, result sign differs.
    // SUB: operands differ in sign, result sign differs from A.
    always_comb begin
        ovf_d = 1'b0;
        case (ctrl_d)
            OP_ADD: ovf_d = (entr1[WIDTH-1] == entr2[WIDTH-1]) &&
                            (sum[WIDTH-1]   != entr1[WIDTH-1]);
            OP_SUB: ovf_d = (entr1[WIDTH-1] != entr2[WIDTH-1]) &&
                            (diff[WIDTH-1]  != entr1[WIDTH-1]);
            default: ovf_d = 1'b0;
        endcase
    end
`else
    assign ovf_d = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Branch-target adder. The shift drops imm_ext's top two bits, which is
    // the same as appending 2'b00 to imm_ext[WIDTH-3:0]; carry-out discarded.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] branch_d;

    assign branch_d = pc_plus4 + (imm_ext << 2);

    // ------------------------------------------------------------------
    // EX/MEM output register. Data loads even when in_valid=0; consumers
    // qualify with out_valid. Stall holds everything.
    // ------------------------------------------------------------------
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] branch_q;
    logic             valid_q;
    logic             ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            branch_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (!stall) begin
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            branch_q <= branch_d;
            valid_q  <= in_valid;
            ovf_q    <= ovf_d;
        end
    end

    assign alu_ctrl   = ctrl_q;
    assign alu_result = result_q;
    assign zero       = zero_q;
    assign branch_pc  = branch_q;
    assign out_valid  = valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//   Directed test of alu_exec_stage (WIDTH=32) against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        in_valid;
    logic [1:0]  aluOp;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] entr1;
    logic [31:0] entr2;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] branch_pc;
    logic        out_valid;
    logic        ovf;

    int pass_cnt = 0;
    int total    = 0;

`ifdef ALU_OVERFLOW_DETECT_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
        .aluOp(aluOp), .func(func), .shamt(shamt), .entr1(entr1),
        .entr2(entr2), .pc_plus4(pc_plus4), .imm_ext(imm_ext),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero),
        .branch_pc(branch_pc), .out_valid(out_valid), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: set inputs.
    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a,
                         input logic [31:0] b);
        aluOp = op; func = fn; shamt = sh; entr1 = a; entr2 = b;
    endtask

    // Advance one clock edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; in_valid = 1'b0;
        pc_plus4 = '0; imm_ext = '0;
        drive(2'b00, 6'd0, 5'd0, 32'd0, 32'd0);
        #2;
        total++;
        if ({alu_ctrl, alu_result, zero, branch_pc, out_valid, ovf} !== '0)
            $display("FAIL reset_initial got ctrl=%h res=%h z=%b br=%h v=%b o=%b exp all 0",
                     alu_ctrl, alu_result, zero, branch_pc, out_valid, ovf);
        else pass_cnt++;
        // Outputs hold at 0 across an edge while reset stays high
        in_valid = 1'b1; drive(2'b00, 6'd0, 5'd0, 32'd3, 32'd4);
        tick();
        total++;
        if ({alu_ctrl, alu_result, out_valid} !== '0)
            $display("FAIL reset_held got ctrl=%h res=%h v=%b exp 0", alu_ctrl, alu_result, out_valid);
        else pass_cnt++;
        #2 reset = 1'b0;
        // First edge after deassertion loads normally
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero, out_valid} !== {4'b0010, 32'd7, 1'b0, 1'b1})
            $display("FAIL reset_first_load got ctrl=%h res=%h z=%b v=%b exp ctrl=2 res=7 z=0 v=1",
                     alu_ctrl, alu_result, zero, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_rtype_arith();
        drive(2'b10, 6'b100000, 5'd0, 32'd5, 32'd7);
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b0010, 32'd12, 1'b0})
            $display("FAIL add got ctrl=%h res=%h z=%b exp 2/0000000c/0", alu_ctrl, alu_result, zero);
        else pass_cnt++;
        drive(2'b10, 6'b100010, 5'd0, 32'd7, 32'd7);
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b0110, 32'd0, 1'b1})
            $display("FAIL sub_zero got ctrl=%h res=%h z=%b exp 6/00000000/1", alu_ctrl, alu_result, zero);
        else pass_cnt++;
    endtask

    task automatic test_logic_compare();
        drive(2'b10, 6'b100100, 5'd0, 32'hF0F0_FFFF, 32'h0FF0_00FF);
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b0000, 32'h00F0_00FF, 1'b0})
            $display("FAIL and got ctrl=%h res=%h z=%b exp 0/00f000ff/0", alu_ctrl, alu_result, zero);
        else pass_cnt++;
        drive(2'b10, 6'b100111, 5'd0, 32'd0, 32'd0);
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b1100, 32'hFFFF_FFFF, 1'b0})
            $display("FAIL nor got ctrl=%h res=%h z=%b exp c/ffffffff/0", alu_ctrl, alu_result, zero);
        else pass_cnt++;
        drive(2'b10, 6'b100110, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
        tick();
        total++;
        if ({alu_ctrl, alu_result} !== {4'b0011, 32'hF00F_F00F})
            $display("FAIL xor got ctrl=%h res=%h exp 3/f00ff00f", alu_ctrl, alu_result);
        else pass_cnt++;
        drive(2'b10, 6'b100101, 5'd0, 32'd1, 32'd2);
        tick();
        total++;
        if ({alu_ctrl, alu_result} !== {4'b0001, 32'd3})
            $display("FAIL or got ctrl=%h res=%h exp 1/00000003", alu_ctrl, alu_result);
        else pass_cnt++;
        drive(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b0111, 32'd1, 1'b0})
            $display("FAIL slt got ctrl=%h res=%h z=%b exp 7/00000001/0", alu_ctrl, alu_result, zero);
        else pass_cnt++;
        drive(2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1);
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b1000, 32'd0, 1'b1})
            $display("FAIL sltu got ctrl=%h res=%h z=%b exp 8/00000000/1", alu_ctrl, alu_result, zero);
        else pass_cnt++;
    endtask

    task automatic test_shift_invalid();
        drive(2'b10, 6'b000011, 5'd4, 32'h1234_5678, 32'h8000_0000);
        tick();
        total++;
        if ({alu_ctrl, alu_result} !== {4'b1001, 32'hF800_0000})
            $display("FAIL sra got ctrl=%h res=%h exp 9/f8000000", alu_ctrl, alu_result);
        else pass_cnt++;
        drive(2'b10, 6'b000010, 5'd4, 32'h1234_5678, 32'h8000_0000);
        tick();
        total++;
        if ({alu_ctrl, alu_result} !== {4'b0101, 32'h0800_0000})
            $display("FAIL srl got ctrl=%h res=%h exp 5/08000000", alu_ctrl, alu_result);
        else pass_cnt++;
        drive(2'b10, 6'b000000, 5'd31, 32'h0, 32'h0000_0003);
        tick();
        total++;
        if ({alu_ctrl, alu_result} !== {4'b0100, 32'h8000_0000})
            $display("FAIL sll got ctrl=%h res=%h exp 4/80000000", alu_ctrl, alu_result);
        else pass_cnt++;
        drive(2'b10, 6'b111111, 5'd3, 32'd9, 32'd6);
        tick();
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b1111, 32'd0, 1'b1})
            $display("FAIL invalid got ctrl=%h res=%h z=%b exp f/00000000/1", alu_ctrl, alu_result, zero);
        else pass_cnt++;
    endtask

    task automatic test_branch_decode();
        pc_plus4 = 32'h0000_0040; imm_ext = 32'hFFFF_FFFE;
        drive(2'b01, 6'b111111, 5'd0, 32'd55, 32'd55);
        tick();
        total++;
        if (branch_pc !== 32'h0000_0038)
            $display("FAIL branch_neg got %h exp 00000038", branch_pc);
        else pass_cnt++;
        total++;
        if ({alu_ctrl, alu_result, zero} !== {4'b0110, 32'd0, 1'b1})
            $display("FAIL aluop01_sub got ctrl=%h res=%h z=%b exp 6/00000000/1", alu_ctrl, alu_result, zero);
        else pass_cnt++;
        pc_plus4 = 32'hFFFF_FFFC; imm_ext = 32'd1;
        drive(2'b11, 6'b100000, 5'd0, 32'h0000_00F0, 32'h0000_0F00);
        tick();
        total++;
        if (branch_pc !== 32'h0000_0000)
            $display("FAIL branch_wrap got %h exp 00000000", branch_pc);
        else pass_cnt++;
        total++;
        if ({alu_ctrl, alu_result} !== {4'b0001, 32'h0000_0FF0})
            $display("FAIL aluop11_or got ctrl=%h res=%h exp 1/00000ff0", alu_ctrl, alu_result);
        else pass_cnt++;
        pc_plus4 = 32'h0000_1000; imm_ext = 32'h0000_0010;
        drive(2'b00, 6'b000010, 5'd0, 32'hFFFF_FFFF, 32'd2);
        tick();
        total++;
        if ({alu_ctrl, alu_result, branch_pc} !== {4'b0010, 32'd1, 32'h0000_1040})
            $display("FAIL aluop00_add got ctrl=%h res=%h br=%h exp 2/00000001/00001040",
                     alu_ctrl, alu_result, branch_pc);
        else pass_cnt++;
    endtask

    task automatic test_valid();
        in_valid = 1'b0;
        drive(2'b10, 6'b100000, 5'd0, 32'd20, 32'd22);
        tick();
        total++;
        if ({out_valid, alu_result} !== {1'b0, 32'd42})
            $display("FAIL invalid_loads got v=%b res=%h exp 0/0000002a", out_valid, alu_result);
        else pass_cnt++;
        in_valid = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1)
            $display("FAIL valid_back got %b exp 1", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        pc_plus4 = 32'h0000_0100; imm_ext = 32'd4;
        drive(2'b10, 6'b100000, 5'd0, 32'd5, 32'd7);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0];
            pc_plus4 = 32'h0000_2000 + i; imm_ext = 32'd100 + i;
            drive(2'b10, 6'b100010, 5'd0, 32'd3 + i, 32'd3);
            tick();
            total++;
            if ({alu_ctrl, alu_result, zero, branch_pc, out_valid} !==
                {4'b0010, 32'd12, 1'b0, 32'h0000_0110, 1'b1})
                $display("FAIL stall_hold%0d got ctrl=%h res=%h z=%b br=%h v=%b exp 2/0000000c/0/00000110/1",
                         i, alu_ctrl, alu_result, zero, branch_pc, out_valid);
            else pass_cnt++;
        end
        // Last stall-cycle inputs: sub 5-3=2, pc 0x2002 + (102<<2)=0x219A
        stall = 1'b0; in_valid = 1'b1;
        tick();
        total++;
        if ({alu_ctrl, alu_result, branch_pc, out_valid} !==
            {4'b0110, 32'd2, 32'h0000_219A, 1'b1})
            $display("FAIL stall_release got ctrl=%h res=%h br=%h v=%b exp 6/00000002/0000219a/1",
                     alu_ctrl, alu_result, branch_pc, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        drive(2'b10, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1);
        tick();
        total++;
        if ({alu_result, ovf} !== {32'h8000_0000, OVF_EN})
            $display("FAIL ovf_add got res=%h ovf=%b exp 80000000/%b", alu_result, ovf, OVF_EN);
        else pass_cnt++;
        drive(2'b01, 6'b000000, 5'd0, 32'h8000_0000, 32'd1);
        tick();
        total++;
        if ({alu_result, ovf} !== {32'h7FFF_FFFF, OVF_EN})
            $display("FAIL ovf_sub got res=%h ovf=%b exp 7fffffff/%b", alu_result, ovf, OVF_EN);
        else pass_cnt++;
        drive(2'b10, 6'b100000, 5'd0, 32'hFFFF_FFFF, 32'd1);
        tick();
        total++;
        if ({alu_result, ovf, zero} !== {32'd0, 1'b0, 1'b1})
            $display("FAIL no_ovf_add got res=%h ovf=%b z=%b exp 00000000/0/1", alu_result, ovf, zero);
        else pass_cnt++;
        // Non-arithmetic op: ovf must drop even with overflow-like operands
        drive(2'b10, 6'b100101, 5'd0, 32'h7FFF_FFFF, 32'd1);
        tick();
        total++;
        if (ovf !== 1'b0)
            $display("FAIL ovf_or got %b exp 0", ovf);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(2'b10, 6'b100111, 5'd0, 32'd0, 32'd0);
        pc_plus4 = 32'h10; imm_ext = 32'h1;
        tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({alu_ctrl, alu_result, zero, branch_pc, out_valid, ovf} !== '0)
            $display("FAIL async_reset got ctrl=%h res=%h z=%b br=%h v=%b o=%b exp all 0",
                     alu_ctrl, alu_result, zero, branch_pc, out_valid, ovf);
        else pass_cnt++;
        #1 reset = 1'b0;
        tick();
        total++;
        if ({alu_ctrl, alu_result, branch_pc, out_valid} !== {4'b1100, 32'hFFFF_FFFF, 32'h14, 1'b1})
            $display("FAIL reset_release_load got ctrl=%h res=%h br=%h v=%b exp c/ffffffff/00000014/1",
                     alu_ctrl, alu_result, branch_pc, out_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rtype_arith();
        test_logic_compare();
        test_shift_invalid();
        test_branch_decode();
        test_valid();
        test_stall();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
